// File: rtl/operand_load_sequencer.sv
// Operand-load sequencer: collects NUM_OPERANDS words (one per inputdata_ready
// handshake) and strobes each into its register slot. It then enables the
// compute stage for COMPUTE_CYCLES cycles and holds done until ack.
// Optional feature macro: OPSEQ_TIMEOUT_EN (WAIT_DATA watchdog, error pulse).
// Outputs come from flops loaded with decodes of the next state, so they match
// a decode of the state register and have no input-to-output combinational path.
module operand_load_sequencer #(
  parameter int unsigned NUM_OPERANDS   = 4,
  parameter int unsigned COMPUTE_CYCLES = 3,
  parameter int unsigned CNT_W          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             inputdata_ready,
  input  logic             ack,
  output logic             loaddata,
  output logic [CNT_W-1:0] load_index,
  output logic             compute_en,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_OPERANDS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COMPUTE_CYCLES - 1);

  // Reject configurations whose compare values do not fit the counters.
  if (NUM_OPERANDS < 1 || NUM_OPERANDS > (1 << CNT_W) ||
      COMPUTE_CYCLES < 1 || COMPUTE_CYCLES > (1 << CNT_W) ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << CNT_W)) begin : g_bad_cfg
    $error("operand_load_sequencer: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_LOAD,
    S_COMPUTE,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_d;

  logic             loaddata_q;
  logic [CNT_W-1:0] load_index_q;
  logic             compute_en_q;
  logic             busy_q;
  logic             done_q;
  logic             error_q;

`ifdef OPSEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  // Next-state and counter update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WAIT_DATA;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      S_WAIT_DATA: begin
        if (inputdata_ready) begin
          state_d = S_LOAD;
        end
`ifdef OPSEQ_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_LOAD: begin
        cnt_d = '0;
        if (idx_q == LAST_IDX) begin
          state_d = S_COMPUTE;
        end else begin
          state_d = S_WAIT_DATA;
          idx_d   = idx_q + CNT_W'(1);
        end
      end
      S_COMPUTE: begin
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (ack) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and registered Moore outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      loaddata_q   <= 1'b0;
      load_index_q <= '0;
      compute_en_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      loaddata_q   <= (state_d == S_LOAD);
      load_index_q <= (state_d == S_LOAD) ? idx_d : '0;
      compute_en_q <= (state_d == S_COMPUTE);
      busy_q       <= (state_d != S_IDLE);
      done_q       <= (state_d == S_DONE);
      error_q      <= err_d;
    end
  end

  assign loaddata   = loaddata_q;
  assign load_index = load_index_q;
  assign compute_en = compute_en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_operand_load_sequencer.sv
// Self-checking bench for operand_load_sequencer: vector table, hand-written
// corner sequences, random stimulus against a run-level reference model.
// Optional feature macro: OPSEQ_TIMEOUT_EN.
module tb_operand_load_sequencer;

  localparam int unsigned NOPS  = 4;
  localparam int unsigned NCOMP = 3;
  localparam int unsigned CW    = 4;
  localparam int unsigned TMO   = 15;

  logic          clk = 1'b0;
  logic          reset, start, ready, ack;
  logic          loaddata, compute_en, busy, done, error;
  logic [CW-1:0] load_index;
  logic          start1, ready1, ack1;
  logic          loaddata1, compute_en1, busy1, done1, error1;
  logic [CW-1:0] load_index1;

  int n_checks = 0;
  int n_fail   = 0;

  operand_load_sequencer #(
    .NUM_OPERANDS(NOPS), .COMPUTE_CYCLES(NCOMP), .CNT_W(CW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .inputdata_ready(ready), .ack(ack),
    .loaddata(loaddata), .load_index(load_index), .compute_en(compute_en),
    .busy(busy), .done(done), .error(error)
  );

  operand_load_sequencer #(
    .NUM_OPERANDS(1), .COMPUTE_CYCLES(1), .CNT_W(CW), .TIMEOUT_CYCLES(TMO)
  ) dut_min (
    .clk(clk), .reset(reset), .start(start1), .inputdata_ready(ready1), .ack(ack1),
    .loaddata(loaddata1), .load_index(load_index1), .compute_en(compute_en1),
    .busy(busy1), .done(done1), .error(error1)
  );

  always #5 clk = ~clk;

  // Reference model: tracks a run in terms of operands loaded, compute cycles left,
  // whether a strobe is due this cycle and whether the result is being offered.
  typedef struct packed {
    bit active;
    bit strobe;
    bit fin;
    bit err;
    int loaded;
    int comp_left;
    int idle_wait;
  } model_t;

  model_t m = '0;

  function automatic model_t model_step(model_t c, bit st, bit rd, bit ak);
    model_t n = c;
    n.err = 1'b0;
    if (!c.active) begin
      if (st) begin
        n.active = 1'b1; n.loaded = 0; n.idle_wait = 0; n.strobe = 1'b0;
      end
    end else if (c.fin) begin
      if (ak) n = '0;
    end else if (c.comp_left > 0) begin
      n.comp_left = c.comp_left - 1;
      if (n.comp_left == 0) n.fin = 1'b1;
    end else if (c.strobe) begin
      n.strobe = 1'b0;
      n.loaded = c.loaded + 1;
      n.idle_wait = 0;
      if (n.loaded == NOPS) n.comp_left = NCOMP;
    end else if (rd) begin
      n.strobe = 1'b1;
    end
`ifdef OPSEQ_TIMEOUT_EN
    else begin
      n.idle_wait = c.idle_wait + 1;
      if (n.idle_wait == TMO) begin
        n = '0;
        n.err = 1'b1;
      end
    end
`endif
    return n;
  endfunction

  function automatic logic [8:0] model_outs(model_t c);
    logic [CW-1:0] idx;
    idx = c.strobe ? CW'(c.loaded) : '0;
    return {c.strobe, idx, c.comp_left > 0, c.active, c.fin, c.err};
  endfunction

  // Advance the model with the same inputs the DUT samples.
  always @(posedge clk or posedge reset) begin
    if (reset) m <= '0;
    else       m <= model_step(m, start, ready, ack);
  end

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
    end
  endtask

  function automatic logic [8:0] dut_outs();
    return {loaddata, load_index, compute_en, busy, done, error};
  endfunction

  // Continuous comparison against the model on the falling edge.
  always @(negedge clk) begin
    check("model", int'(dut_outs()), int'(model_outs(m)));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit st; bit rd; bit ak;
    bit ld; int idx; bit ce; bit bz; bit dn;
  } vec_t;

  vec_t vt[$];
  int c, first, cnt_a, cnt_b, cnt_c, v_idx, v_cyc;
  int q[$];

  initial begin : timeout_guard
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    if (NOPS > (1 << CW) || NCOMP > (1 << CW)) begin
      $display("FAIL params: NUM_OPERANDS/COMPUTE_CYCLES exceed 2**CNT_W");
      $fatal(1, "bad parameters");
    end

    reset = 1'b1; start = 0; ready = 0; ack = 0; start1 = 0; ready1 = 0; ack1 = 0;
    tick();
    check("reset_outs", int'(dut_outs()), 0);
    check("reset_outs_min", int'({loaddata1, load_index1, compute_en1, busy1, done1, error1}), 0);
    tick();
    reset = 1'b0;

    // Nominal run with ignored start/ack pulses, expected values per cycle.
    //         st rd ak  ld idx ce bz dn
    vt.push_back('{1, 1, 0, 0, 0, 0, 1, 0});
    vt.push_back('{0, 1, 0, 1, 0, 0, 1, 0});
    vt.push_back('{1, 1, 0, 0, 0, 0, 1, 0});
    vt.push_back('{0, 1, 0, 1, 1, 0, 1, 0});
    vt.push_back('{0, 1, 0, 0, 0, 0, 1, 0});
    vt.push_back('{0, 1, 0, 1, 2, 0, 1, 0});
    vt.push_back('{0, 1, 1, 0, 0, 0, 1, 0});
    vt.push_back('{0, 1, 0, 1, 3, 0, 1, 0});
    vt.push_back('{1, 1, 0, 0, 0, 1, 1, 0});
    vt.push_back('{1, 0, 1, 0, 0, 1, 1, 0});
    vt.push_back('{0, 0, 0, 0, 0, 1, 1, 0});
    vt.push_back('{0, 0, 0, 0, 0, 0, 1, 1});
    vt.push_back('{0, 0, 0, 0, 0, 0, 1, 1});
    vt.push_back('{1, 0, 1, 0, 0, 0, 0, 0});
    vt.push_back('{0, 0, 0, 0, 0, 0, 0, 0});
    foreach (vt[i]) begin
      start = vt[i].st; ready = vt[i].rd; ack = vt[i].ak;
      tick();
      check($sformatf("vec%0d", i), int'(dut_outs()),
            int'({vt[i].ld, CW'(vt[i].idx), vt[i].ce, vt[i].bz, vt[i].dn, 1'b0}));
    end

    // ack already high when DONE is entered: done visible exactly one cycle.
    start = 1; ready = 1; ack = 1;
    tick(); start = 0;
    c = 1; first = 0; cnt_a = 0;
    while (c < 40) begin
      if (done && first == 0) first = c;
      cnt_a += int'(done);
      if (!busy) break;
      tick(); c++;
    end
    check("ackentry_first_done", first, 2 * NOPS + NCOMP + 1);
    check("ackentry_done_cycles", cnt_a, 1);
    check("ackentry_idle_cycle", c, 2 * NOPS + NCOMP + 2);
    ack = 0; ready = 0;
    tick();

    // Stalled source: one-cycle ready pulses separated by five idle cycles.
    start = 1; ready = 0;
    tick(); start = 0;
    c = 0; cnt_a = 0; q.delete();
    while (!done && c < 200) begin
      ready = (c % 6 == 0);
      tick(); c++;
      if (loaddata) q.push_back(int'(load_index));
      if (!busy) cnt_a++;
    end
    check("stall_done", int'(done), 1);
    check("stall_strobes", q.size(), NOPS);
    foreach (q[i]) check($sformatf("stall_idx%0d", i), q[i], i);
    check("stall_busy_drops", cnt_a, 0);
    ready = 0; ack = 1;
    tick(); ack = 0;

    // Asynchronous reset during the second compute cycle, then a clean run.
    start = 1; ready = 1;
    tick(); start = 0;
    c = 0;
    while (!compute_en && c < 40) begin tick(); c++; end
    check("rst_reach_compute", int'(compute_en), 1);
    tick();
    #2 reset = 1;
    #1 check("rst_async_outs", int'(dut_outs()), 0);
    tick();
    reset = 0;
    start = 1;
    tick(); start = 0;
    c = 1;
    while (!done && c < 40) begin tick(); c++; end
    check("rst_rerun_latency", c, 2 * NOPS + NCOMP + 1);
    ack = 1;
    tick(); ack = 0; ready = 0;
    check("rst_rerun_idle", int'(busy), 0);

    // Minimum configuration: one operand, one compute cycle.
    start1 = 1; ready1 = 1;
    tick(); start1 = 0;
    cnt_a = 0; cnt_b = 0; first = 0; v_idx = -1; v_cyc = 0;
    for (int k = 1; k <= 8; k++) begin
      if (loaddata1) begin cnt_a++; v_idx = int'(load_index1); v_cyc = k; end
      cnt_b += int'(compute_en1);
      if (done1 && first == 0) begin first = k; ack1 = 1; end
      tick();
    end
    check("min_loads", cnt_a, 1);
    check("min_load_idx", v_idx, 0);
    check("min_load_cycle", v_cyc, 2);
    check("min_compute_cycles", cnt_b, 1);
    check("min_done_cycle", first, 4);
    check("min_idle_after_ack", int'(busy1), 0);
    ack1 = 0; ready1 = 0;

`ifdef OPSEQ_TIMEOUT_EN
    // Two operands loaded, then the source goes silent.
    start = 1; ready = 0;
    tick(); start = 0;
    ready = 1; tick();
    ready = 0; tick();
    ready = 1; tick();
    ready = 0;
    c = 0; cnt_a = 0; cnt_b = 0; cnt_c = 1; first = 0;
    while (c < 40) begin
      tick(); c++;
      if (error) begin cnt_a++; cnt_c = int'(busy); first = c; end
      cnt_b += int'(done);
    end
    check("tmo_error_pulses", cnt_a, 1);
    check("tmo_error_cycle", first, TMO + 1);
    check("tmo_no_done", cnt_b, 0);
    check("tmo_busy_at_error", cnt_c, 0);

    // Ready arriving on the limit cycle wins.
    start = 1; ready = 0;
    tick(); start = 0;
    repeat (TMO - 1) tick();
    ready = 1;
    tick();
    check("tmo_limit_load", int'(loaddata), 1);
    check("tmo_limit_no_error", int'(error), 0);
    c = 0;
    while (!done && c < 60) begin tick(); c++; end
    check("tmo_limit_done", int'(done), 1);
    ack = 1; tick(); ack = 0; ready = 0;
`endif

    // Random stimulus, checked by the model on every falling edge.
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 3) == 0);
      ready = ($urandom_range(0, 2) == 0);
      ack   = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #3 reset = 1;
        tick();
        reset = 0;
      end else begin
        tick();
      end
    end
    start = 0; ready = 0; ack = 0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
